// File: rtl/keyed_lock_frontend_if.sv
// Handshake/bus bundle for keyed_lock_frontend: serial key load, keyed input/output paths, LUT gates.
// key_err is present only when KEY_PARITY_EN is defined.
interface keyed_lock_frontend_if #(
  parameter int DATA_W = 36,
  parameter int OUT_W  = 7,
  parameter int MUX_N  = 1
);
  logic                 key_bit;
  logic                 key_valid;
  logic                 key_ready;
  logic                 key_loaded;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic [DATA_W-1:0]    core_in;
  logic                 core_in_valid;
  logic [OUT_W-1:0]     core_out;
  logic [2*MUX_N-1:0]   lut_sel;
  logic [MUX_N-1:0]     lut_out;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
`ifdef KEY_PARITY_EN
  logic                 key_err;
`endif

  modport master (
    output key_bit, key_valid, in_data, in_valid, core_out, lut_sel,
    input  key_ready, key_loaded, core_in, core_in_valid, lut_out, out_data, out_valid
`ifdef KEY_PARITY_EN
    , input key_err
`endif
  );

  modport slave (
    input  key_bit, key_valid, in_data, in_valid, core_out, lut_sel,
    output key_ready, key_loaded, core_in, core_in_valid, lut_out, out_data, out_valid
`ifdef KEY_PARITY_EN
    , output key_err
`endif
  );
endinterface

// File: rtl/keyed_lock_frontend.sv
// Clocked key-gating frontend: serial shadow/active key pair, XOR gates on core I/O, 4-entry LUT gates.
// Optional KEY_PARITY_EN: even-parity bit appended to each key frame, key_err on mismatch.
module keyed_lock_frontend #(
  parameter int DATA_W = 36,
  parameter int OUT_W  = 7,
  parameter int MUX_N  = 1
) (
  input logic                 clk,
  input logic                 rst,
  keyed_lock_frontend_if.slave bus
);
  localparam int KEY_W    = DATA_W + OUT_W + 4*MUX_N;
  localparam int LUT_BASE = DATA_W + OUT_W;
`ifdef KEY_PARITY_EN
  localparam int FRAME_W  = KEY_W + 1;
`else
  localparam int FRAME_W  = KEY_W;
`endif
  localparam int CNT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ARMED, RELOAD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   active_q, active_d;
  logic               key_loaded_q, key_loaded_d;
  logic               key_err_q, key_err_d;
  logic [DATA_W-1:0]  core_in_q, core_in_d;
  logic               core_in_valid_q, core_in_valid_d;
  logic [MUX_N-1:0]   lut_out_q, lut_out_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
`ifndef KEY_PARITY_EN
  logic [KEY_W-1:0]   shadow_next;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    key_loaded_d = key_loaded_q;
    key_err_d    = 1'b0;
`ifndef KEY_PARITY_EN
    shadow_next  = shadow_q;
`endif
    if (bus.key_valid) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
`ifdef KEY_PARITY_EN
        // Parity bit lands here; the shadow is already complete.
        if (bus.key_bit == ^shadow_q) begin
          active_d     = shadow_q;
          key_loaded_d = 1'b1;
          state_d      = ARMED;
        end else begin
          key_err_d = 1'b1;
          state_d   = (state_q == RELOAD) ? ARMED : IDLE;
        end
        shadow_d = '0;
`else
        // Final key bit goes straight into the active copy on the same edge.
        shadow_next[cnt_q] = bus.key_bit;
        shadow_d           = shadow_next;
        active_d           = shadow_next;
        key_loaded_d       = 1'b1;
        state_d            = ARMED;
`endif
      end else begin
        shadow_d[cnt_q] = bus.key_bit;
        cnt_d           = cnt_q + 1'b1;
        if (state_q == IDLE)  state_d = SHIFT;
        if (state_q == ARMED) state_d = RELOAD;
      end
    end
  end

  always_comb begin
    core_in_d       = key_loaded_q ? (bus.in_data ^ active_q[DATA_W-1:0]) : '0;
    core_in_valid_d = key_loaded_q & bus.in_valid;
    out_data_d      = key_loaded_q ? (bus.core_out ^ active_q[LUT_BASE-1:DATA_W]) : '0;
    out_valid_d     = key_loaded_q & core_in_valid_q;
  end

  for (genvar g = 0; g < MUX_N; g++) begin : g_lut
    logic [3:0] tbl;
    assign tbl          = active_q[LUT_BASE + 4*g +: 4];
    assign lut_out_d[g] = key_loaded_q & tbl[bus.lut_sel[2*g+1:2*g]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      shadow_q        <= '0;
      active_q        <= '0;
      key_loaded_q    <= 1'b0;
      key_err_q       <= 1'b0;
      core_in_q       <= '0;
      core_in_valid_q <= 1'b0;
      lut_out_q       <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      key_loaded_q    <= key_loaded_d;
      key_err_q       <= key_err_d;
      core_in_q       <= core_in_d;
      core_in_valid_q <= core_in_valid_d;
      lut_out_q       <= lut_out_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign bus.key_ready     = 1'b1;
  assign bus.key_loaded    = key_loaded_q;
  assign bus.core_in       = core_in_q;
  assign bus.core_in_valid = core_in_valid_q;
  assign bus.lut_out       = lut_out_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_valid     = out_valid_q;
`ifdef KEY_PARITY_EN
  assign bus.key_err       = key_err_q;
`else
  logic unused_err;
  assign unused_err = key_err_q;
`endif
endmodule

// File: tb/tb_keyed_lock_frontend.sv
// Directed bench for keyed_lock_frontend: reset, key loads, keyed datapath table, reload swap, reset abort.
module tb_keyed_lock_frontend;
  localparam int DATA_W = 36;
  localparam int OUT_W  = 7;
  localparam int MUX_N  = 1;
  localparam int KEY_W  = DATA_W + OUT_W + 4*MUX_N;
`ifdef KEY_PARITY_EN
  localparam int NBITS  = KEY_W + 1;
`else
  localparam int NBITS  = KEY_W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keyed_lock_frontend_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MUX_N(MUX_N)) bus ();
  keyed_lock_frontend #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MUX_N(MUX_N)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit exp_civ_prev = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              v;
    logic [1:0]        sel;
    logic [OUT_W-1:0]  co;
    logic [DATA_W-1:0] ci;
    logic              civ;
    logic              lut;
    logic [OUT_W-1:0]  od;
    logic              ov;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One clock with random data; ku/lu describe the key in force before the edge.
  task automatic cycle(input logic [KEY_W-1:0] ku, input bit lu, input bit stream,
                       input bit kl_after, input bit err_after, input bit chk_ov);
    logic [DATA_W-1:0] d;
    logic [OUT_W-1:0]  co;
    logic [1:0]        sel;
    bit                ov_exp;
    d   = DATA_W'({$urandom(), $urandom()});
    co  = OUT_W'($urandom());
    sel = 2'($urandom());
    bus.in_data  = d;
    bus.in_valid = stream;
    bus.core_out = co;
    bus.lut_sel  = sel;
    ov_exp = lu & exp_civ_prev;
    step;
    chk("core_in", 64'(bus.core_in), lu ? 64'(d ^ ku[DATA_W-1:0]) : 64'd0);
    chk("core_in_valid", 64'(bus.core_in_valid), 64'(lu & stream));
    chk("out_data", 64'(bus.out_data), lu ? 64'(co ^ ku[DATA_W+OUT_W-1:DATA_W]) : 64'd0);
    chk("lut_out", 64'(bus.lut_out), lu ? 64'(ku[DATA_W+OUT_W+int'(sel)]) : 64'd0);
    chk("key_loaded", 64'(bus.key_loaded), 64'(kl_after));
    chk("key_ready", 64'(bus.key_ready), 64'd1);
    if (chk_ov) chk("out_valid", 64'(bus.out_valid), 64'(ov_exp));
`ifdef KEY_PARITY_EN
    chk("key_err", 64'(bus.key_err), 64'(err_after));
`else
    if (err_after) chk("err_arg", 64'd1, 64'd0);
`endif
    exp_civ_prev = lu & stream;
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] old_k,
                          input bit was_loaded, input bit gap, input bit stream, input bit bad_par);
    bit done;
    bit last_ok;
    done = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      bus.key_valid = 1'b1;
      bus.key_bit   = (i < KEY_W) ? k[i] : ((^k) ^ bad_par);
      last_ok = (i == NBITS - 1) && !bad_par;
      cycle(done ? k : old_k, was_loaded || done, stream,
            was_loaded || done || last_ok, (i == NBITS - 1) && bad_par, i > 0);
      done = done || last_ok;
      if (gap) begin
        bus.key_valid = 1'b0;
        cycle(done ? k : old_k, was_loaded || done, stream, was_loaded || done, 1'b0, 1'b1);
      end
    end
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  localparam logic [KEY_W-1:0] K0 = '0;
  localparam logic [KEY_W-1:0] K1 = {4'b0110, 7'h7F, {DATA_W{1'b1}}};
  localparam logic [KEY_W-1:0] K2 = {4'b1001, 7'h0F, 36'h0_F0F0_F0F0};

  initial begin
    tbl[0] = '{36'h0_0000_0000, 1'b1, 2'd0, 7'h00, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 7'h7F, 1'b0};
    tbl[1] = '{36'h5_A5A5_A5A5, 1'b1, 2'd1, 7'h7F, 36'hA_5A5A_5A5A, 1'b1, 1'b1, 7'h00, 1'b1};
    tbl[2] = '{36'hF_0000_000F, 1'b0, 2'd2, 7'h55, 36'h0_FFFF_FFF0, 1'b0, 1'b1, 7'h2A, 1'b1};
    tbl[3] = '{36'h1_2345_6789, 1'b1, 2'd3, 7'h0F, 36'hE_DCBA_9876, 1'b1, 1'b0, 7'h70, 1'b0};

    rst = 1'b1;
    bus.key_bit = 1'b0; bus.key_valid = 1'b0;
    bus.in_data = '0;   bus.in_valid = 1'b0;
    bus.core_out = '0;  bus.lut_sel = '0;
    step; step;
    chk("rst_key_loaded", 64'(bus.key_loaded), 64'd0);
    chk("rst_core_in", 64'(bus.core_in), 64'd0);
    chk("rst_civ", 64'(bus.core_in_valid), 64'd0);
    chk("rst_lut_out", 64'(bus.lut_out), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
    rst = 1'b0;

    // No key: inputs ignored.
    bus.in_data = '1; bus.in_valid = 1'b1; bus.core_out = '1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("nokey_core_in", 64'(bus.core_in), 64'd0);
      chk("nokey_civ", 64'(bus.core_in_valid), 64'd0);
      chk("nokey_out_valid", 64'(bus.out_valid), 64'd0);
      chk("nokey_key_loaded", 64'(bus.key_loaded), 64'd0);
    end
    bus.in_valid = 1'b0;
    exp_civ_prev = 1'b0;

    // All-zero key, then pass-through check with two-cycle latency.
    load_key(K0, K0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_data = 36'h5_A5A5_A5A5; bus.in_valid = 1'b1; bus.core_out = '0;
    step;
    chk("k0_core_in", 64'(bus.core_in), 64'h5_A5A5_A5A5);
    chk("k0_civ", 64'(bus.core_in_valid), 64'd1);
    bus.in_valid = 1'b0; bus.core_out = 7'h55;
    step;
    chk("k0_out_data", 64'(bus.out_data), 64'h55);
    chk("k0_out_valid", 64'(bus.out_valid), 64'd1);
    step;
    chk("k0_out_valid_drop", 64'(bus.out_valid), 64'd0);

    // Inverting key with XOR-style LUT table, applied from the vector table.
    load_key(K1, K0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = tbl[i].d; bus.in_valid = tbl[i].v;
      bus.lut_sel = tbl[i].sel; bus.core_out = tbl[i].co;
      step;
      chk($sformatf("tbl%0d_core_in", i), 64'(bus.core_in), 64'(tbl[i].ci));
      chk($sformatf("tbl%0d_civ", i), 64'(bus.core_in_valid), 64'(tbl[i].civ));
      chk($sformatf("tbl%0d_lut_out", i), 64'(bus.lut_out), 64'(tbl[i].lut));
      chk($sformatf("tbl%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].od));
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
    end
    bus.in_valid = 1'b0;
    step;
    exp_civ_prev = 1'b0;

    // Reload with stalled key bits while data streams; swap must be clean.
    load_key(K2, K1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset 20 bits into a reload: everything discarded.
    for (int i = 0; i < 20; i++) begin
      bus.key_valid = 1'b1; bus.key_bit = K1[i];
      step;
    end
    bus.key_valid = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort_key_loaded", 64'(bus.key_loaded), 64'd0);
    chk("abort_core_in", 64'(bus.core_in), 64'd0);
    chk("abort_out_data", 64'(bus.out_data), 64'd0);
    chk("abort_lut_out", 64'(bus.lut_out), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = '0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("abort_civ", 64'(bus.core_in_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    exp_civ_prev = 1'b0;
    load_key(K1, K0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = '0;
    step;
    chk("fresh_civ", 64'(bus.core_in_valid), 64'd1);
    chk("fresh_core_in", 64'(bus.core_in), 64'hF_FFFF_FFFF);
    bus.in_valid = 1'b0;
    step;
    exp_civ_prev = 1'b0;

`ifdef KEY_PARITY_EN
    // Bad parity while armed: key_err pulse, K1 stays active.
    load_key(K2, K1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = '0;
    step;
    chk("par_key_err_clear", 64'(bus.key_err), 64'd0);
    chk("par_key_loaded", 64'(bus.key_loaded), 64'd1);
    chk("par_core_in_old_key", 64'(bus.core_in), 64'hF_FFFF_FFFF);
    bus.in_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
